// File: rtl/adc_conversion_scheduler.sv
// Purpose : arbitrates two requesters and a periodic CH0/CH1 auto-scan onto one MCP3002 conversion engine.
// Latency : req_ack in cycle n, conv_start in n+1, resp_valid no earlier than n+3 (one conversion in flight).
// Backpres: requesters hold req until req_ack; resp_valid is a pulse with no backpressure.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req, req_ch, req_ack     requester levels, channel select per requester, one-cycle grant pulses
//   auto_en                  enables the periodic auto-scan
//   conv_start, conv_ch      one-cycle start pulse and channel to the SPI-level engine
//   conv_done, conv_data     completion pulse and result from the engine
//   resp_valid/id/data/err   one-cycle result to the granted requester (data 0 on timeout)
//   latest_ch0, latest_ch1   last successful auto-scan sample per channel
//   busy                     high whenever a conversion is being sequenced
module adc_conversion_scheduler #(
   parameter int PERIOD  = 1000,
   parameter int TIMEOUT = 64,
   parameter int DW      = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   input  logic [1:0]    req_ch,
   output logic [1:0]    req_ack,
   input  logic          auto_en,
   output logic          conv_start,
   output logic          conv_ch,
   input  logic          conv_done,
   input  logic [DW-1:0] conv_data,
   output logic          resp_valid,
   output logic          resp_id,
   output logic [DW-1:0] resp_data,
   output logic          resp_err,
   output logic [DW-1:0] latest_ch0,
   output logic [DW-1:0] latest_ch1,
   output logic          busy
);

   localparam int PW = $clog2(PERIOD);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic [1:0] {SRC_REQ0, SRC_REQ1, SRC_AUTO} src_t;

   state_t        state;
   src_t          src;
   logic          rr;        // 0: requester 0 wins a tie, 1: requester 1 wins
   logic          auto_ch;   // channel of the next auto-scan conversion
   logic [PW-1:0] pcnt;
   logic          auto_due;
   logic [TW-1:0] tcnt;

   logic gnt_r0;
   logic gnt_r1;
   logic gnt_auto;

   // Grant decision, only meaningful in IDLE. Auto-scan only fills idle slots.
   always_comb begin
      gnt_r0   = 1'b0;
      gnt_r1   = 1'b0;
      gnt_auto = 1'b0;
      if (state == IDLE) begin
         case (req)
            2'b01:   gnt_r0 = 1'b1;
            2'b10:   gnt_r1 = 1'b1;
            2'b11: begin
               if (rr) gnt_r1 = 1'b1;
               else    gnt_r0 = 1'b1;
            end
            default: gnt_auto = auto_due;
         endcase
      end
   end

   // Period timer. A wrap in the same cycle as an auto grant re-arms auto_due,
   // so that wrap is not lost; wraps while already pending simply collapse.
   always_ff @(posedge clk) begin
      if (rst || !auto_en) begin
         pcnt     <= '0;
         auto_due <= 1'b0;
      end else if (pcnt == PERIOD_LAST) begin
         pcnt     <= '0;
         auto_due <= 1'b1;
      end else begin
         pcnt <= pcnt + PW'(1);
         if (gnt_auto) auto_due <= 1'b0;
      end
   end

   // Sequencer. All outputs are registered, so each port shows the effect of a
   // state's decision in the following cycle (resp_* are visible during RESP).
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         src        <= SRC_REQ0;
         rr         <= 1'b0;
         auto_ch    <= 1'b0;
         tcnt       <= '0;
         req_ack    <= '0;
         conv_start <= 1'b0;
         conv_ch    <= 1'b0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         latest_ch0 <= '0;
         latest_ch1 <= '0;
         busy       <= 1'b0;
      end else begin
         req_ack    <= '0;
         conv_start <= 1'b0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (gnt_r0) begin
                  src     <= SRC_REQ0;
                  conv_ch <= req_ch[0];
                  req_ack <= 2'b01;
               end else if (gnt_r1) begin
                  src     <= SRC_REQ1;
                  conv_ch <= req_ch[1];
                  req_ack <= 2'b10;
               end else if (gnt_auto) begin
                  src     <= SRC_AUTO;
                  conv_ch <= auto_ch;
               end
               if (gnt_r0 || gnt_r1 || gnt_auto) begin
                  state <= ISSUE;
                  busy  <= 1'b1;
               end
               // Priority only rotates when both requesters actually contended.
               if (req == 2'b11) rr <= ~rr;
            end

            ISSUE: begin
               conv_start <= 1'b1;
               tcnt       <= '0;
               state      <= WAIT;
            end

            WAIT: begin
               // conv_done wins over a timeout reached in the same cycle.
               if (conv_done || (tcnt == TIMEOUT_LAST)) begin
                  state <= RESP;
                  if (src == SRC_AUTO) begin
                     if (conv_done) begin
                        if (conv_ch) latest_ch1 <= conv_data;
                        else         latest_ch0 <= conv_data;
                     end
                     auto_ch <= ~auto_ch;
                  end else begin
                     resp_valid <= 1'b1;
                     resp_id    <= (src == SRC_REQ1);
                     resp_err   <= ~conv_done;
                     resp_data  <= conv_done ? conv_data : '0;
                  end
               end else if (tcnt != TIMEOUT_LAST) begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_conversion_scheduler.sv
// Purpose : directed bench for adc_conversion_scheduler with a transaction-timing reference model.
// Latency : model predicts every registered output per cycle; outputs sampled on the falling edge.
// Backpres: the bench plays both requesters and the ADC engine (configurable response delay).
module tb_adc_conversion_scheduler;

   localparam int PERIOD  = 20;
   localparam int TIMEOUT = 8;
   localparam int DW      = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req;
   logic [1:0]    req_ch;
   logic [1:0]    req_ack;
   logic          auto_en;
   logic          conv_start;
   logic          conv_ch;
   logic          conv_done;
   logic [DW-1:0] conv_data;
   logic          resp_valid;
   logic          resp_id;
   logic [DW-1:0] resp_data;
   logic          resp_err;
   logic [DW-1:0] latest_ch0;
   logic [DW-1:0] latest_ch1;
   logic          busy;

   adc_conversion_scheduler #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_ch     (req_ch),
      .req_ack    (req_ack),
      .auto_en    (auto_en),
      .conv_start (conv_start),
      .conv_ch    (conv_ch),
      .conv_done  (conv_done),
      .conv_data  (conv_data),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .latest_ch0 (latest_ch0),
      .latest_ch1 (latest_ch1),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- engine emulation ----------------
   int            cyc       = 0;
   int            eng_delay = 1;   // 0: engine never answers
   int            eng_due   = -1;
   logic          eng_pulse = 1'b0;
   logic [DW-1:0] eng_dat   = '0;
   logic [DW-1:0] eng_q[$];
   logic          force_done = 1'b0;
   logic [DW-1:0] force_data = '0;

   assign conv_done = force_done | eng_pulse;
   assign conv_data = force_done ? force_data : eng_dat;

   always @(negedge clk) begin
      if (conv_start === 1'b1 && eng_delay > 0) begin
         eng_due = cyc + eng_delay;
         if (eng_q.size() > 0) eng_dat = eng_q.pop_front();
         else                  eng_dat = 10'h155;
      end
      eng_pulse = (cyc == eng_due);
   end

   // ---------------- reference model ----------------
   // Works from timestamps: grant edge g, start at g+1, conversion may finish at
   // edges g+2 .. g+1+TIMEOUT, response shown one cycle, next grant two edges later.
   logic [1:0]    x_ack   = '0;
   logic          x_start = 1'b0;
   logic          x_ch    = 1'b0;
   logic          x_rvld  = 1'b0;
   logic          x_rid   = 1'b0;
   logic [DW-1:0] x_rdata = '0;
   logic          x_rerr  = 1'b0;
   logic [DW-1:0] x_lat0  = '0;
   logic [DW-1:0] x_lat1  = '0;
   logic          x_busy  = 1'b0;

   bit m_active = 0, m_rr = 0, m_who = 0, m_src_auto = 0, m_auto_ch = 0, m_due = 0;
   int m_g = 0, m_f = -1, m_pcnt = 0;

   always @(posedge clk) begin
      bit took_auto, fin, ok;
      int k;
      cyc++;
      x_ack = '0; x_start = 0; x_rvld = 0; x_rid = 0; x_rdata = '0; x_rerr = 0;
      took_auto = 0; fin = 0; ok = 0;
      if (rst) begin
         m_active = 0; m_f = -1; m_rr = 0; m_auto_ch = 0; m_pcnt = 0; m_due = 0;
         x_ch = 0; x_busy = 0; x_lat0 = '0; x_lat1 = '0;
      end else begin
         if (!m_active) begin
            if (req != 2'b00) begin
               if (req == 2'b11) begin
                  m_who = m_rr;
                  m_rr  = !m_rr;
               end else begin
                  m_who = req[1];
               end
               m_src_auto = 0;
               x_ch = req_ch[m_who];
               x_ack[m_who] = 1'b1;
               m_active = 1;
            end else if (m_due) begin
               m_src_auto = 1;
               took_auto  = 1;
               x_ch = m_auto_ch;
               m_active = 1;
            end
            if (m_active) begin
               m_g = cyc; m_f = -1; x_busy = 1;
            end
         end else if (m_f >= 0) begin
            m_active = 0; x_busy = 0;
         end else if (cyc == m_g + 1) begin
            x_start = 1;
         end else begin
            k = cyc - m_g - 1;
            if (conv_done) begin fin = 1; ok = 1; end
            else if (k >= TIMEOUT) fin = 1;
         end
         if (fin) begin
            m_f = cyc;
            if (!m_src_auto) begin
               x_rvld  = 1;
               x_rid   = m_who;
               x_rdata = ok ? conv_data : '0;
               x_rerr  = !ok;
            end else begin
               if (ok) begin
                  if (x_ch) x_lat1 = conv_data;
                  else      x_lat0 = conv_data;
               end
               m_auto_ch = !m_auto_ch;
            end
         end
         if (!auto_en) begin
            m_pcnt = 0; m_due = 0;
         end else if (m_pcnt == PERIOD - 1) begin
            m_pcnt = 0; m_due = 1;
         end else begin
            m_pcnt++;
            if (took_auto) m_due = 0;
         end
      end
   end

   // ---------------- per-cycle compare and event log ----------------
   bit ack_q[$];
   bit rid_q[$];
   int n_ack = 0, n_start = 0, n_resp = 0;

   always @(negedge clk) begin
      if (cyc >= 1) begin
         chk("req_ack",    32'(req_ack),    32'(x_ack));
         chk("conv_start", 32'(conv_start), 32'(x_start));
         chk("conv_ch",    32'(conv_ch),    32'(x_ch));
         chk("resp_valid", 32'(resp_valid), 32'(x_rvld));
         chk("resp_id",    32'(resp_id),    32'(x_rid));
         chk("resp_data",  32'(resp_data),  32'(x_rdata));
         chk("resp_err",   32'(resp_err),   32'(x_rerr));
         chk("latest_ch0", 32'(latest_ch0), 32'(x_lat0));
         chk("latest_ch1", 32'(latest_ch1), 32'(x_lat1));
         chk("busy",       32'(busy),       32'(x_busy));
         if (req_ack !== 2'b00) begin ack_q.push_back(req_ack[1]); n_ack++; end
         if (conv_start === 1'b1) n_start++;
         if (resp_valid === 1'b1) begin rid_q.push_back(resp_id); n_resp++; end
      end
   end

   function automatic logic sig_now(input int which);
      case (which)
         0:       return req_ack[0];
         1:       return req_ack[1];
         2:       return conv_start;
         3:       return resp_valid;
         default: return |req_ack;
      endcase
   endfunction

   // Called on a falling edge; returns on the falling edge where the signal is high.
   task automatic wait_sig(input int which, input int limit);
      int i = 0;
      while (i < limit && sig_now(which) !== 1'b1) begin
         @(negedge clk);
         i++;
      end
      chk($sformatf("wait_sig_%0d", which), 32'(sig_now(which)), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int a0, r0, c0, st_c, ack_c, s1;
      rst = 1'b1; req = 2'b00; req_ch = 2'b00; auto_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_latest_ch0", 32'(latest_ch0), 32'd0);

      // single request, engine answers 3 cycles after start
      @(negedge clk);
      a0 = n_ack; eng_delay = 3; eng_q.push_back(10'h2A5);
      req_ch = 2'b01; req = 2'b01;
      wait_sig(0, 10); ack_c = cyc; req = 2'b00;
      chk("t1_conv_ch", 32'(conv_ch), 32'd1);
      wait_sig(3, 30);
      chk("t1_ack_to_resp", 32'(cyc - ack_c), 32'd5);
      chk("t1_resp_id",     32'(resp_id),     32'd0);
      chk("t1_resp_data",   32'(resp_data),   32'h2A5);
      chk("t1_resp_err",    32'(resp_err),    32'd0);
      chk("t1_ack_count",   32'(n_ack - a0),  32'd1);

      // contention, both held, engine answers after 1 cycle
      repeat (3) @(negedge clk);
      a0 = ack_q.size(); r0 = rid_q.size(); eng_delay = 1;
      req_ch = 2'b10; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         wait_sig(4, 20);
      end
      req = 2'b00;
      repeat (8) @(negedge clk);
      chk("t2_grant_count", 32'(ack_q.size() - a0), 32'd4);
      chk("t2_resp_count",  32'(rid_q.size() - r0), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (ack_q.size() > a0 + k) chk($sformatf("t2_grant_%0d", k), 32'(ack_q[a0 + k]), 32'(k % 2));
         if (rid_q.size() > r0 + k) chk($sformatf("t2_rid_%0d", k),   32'(rid_q[r0 + k]), 32'(k % 2));
      end

      // timeout with no engine answer, then a stray conv_done in IDLE
      repeat (3) @(negedge clk);
      eng_delay = 0; req_ch = 2'b00; req = 2'b10;
      wait_sig(1, 10); ack_c = cyc; req = 2'b00;
      wait_sig(2, 10); st_c = cyc;
      wait_sig(3, 40);
      chk("t3_wait_to_resp", 32'(cyc - st_c),  32'd8);
      chk("t3_ack_to_resp",  32'(cyc - ack_c), 32'd9);
      chk("t3_resp_id",      32'(resp_id),     32'd1);
      chk("t3_resp_err",     32'(resp_err),    32'd1);
      chk("t3_resp_data",    32'(resp_data),   32'd0);
      repeat (3) @(negedge clk);
      r0 = n_resp; force_data = 10'h123; force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("t3_stray_done_ignored", 32'(n_resp - r0), 32'd0);

      // conv_done on the timeout threshold cycle counts as success
      eng_delay = TIMEOUT - 1; eng_q.push_back(10'h0AA);
      req_ch = 2'b00; req = 2'b01;
      wait_sig(0, 10); req = 2'b00;
      wait_sig(2, 10); st_c = cyc;
      wait_sig(3, 40);
      chk("t3b_wait_to_resp", 32'(cyc - st_c), 32'd8);
      chk("t3b_resp_err",     32'(resp_err),   32'd0);
      chk("t3b_resp_data",    32'(resp_data),  32'h0AA);

      // auto-scan alone
      repeat (3) @(negedge clk);
      r0 = n_resp; eng_delay = 2;
      eng_q.push_back(10'h100); eng_q.push_back(10'h3FF);
      auto_en = 1'b1;
      wait_sig(2, 60); s1 = cyc;
      chk("t4_first_ch", 32'(conv_ch), 32'd0);
      @(negedge clk);
      wait_sig(2, 60);
      chk("t4_start_spacing", 32'(cyc - s1), 32'd20);
      chk("t4_second_ch",     32'(conv_ch),  32'd1);
      repeat (6) @(negedge clk);
      chk("t4_latest_ch0", 32'(latest_ch0),   32'h100);
      chk("t4_latest_ch1", 32'(latest_ch1),   32'h3FF);
      chk("t4_no_resp",    32'(n_resp - r0),  32'd0);
      auto_en = 1'b0;
      repeat (30) @(negedge clk);
      chk("t4_latest_kept", 32'(latest_ch0), 32'h100);

      // requester 1 rises in the cycle auto_due appears
      a0 = n_ack; eng_delay = 0; auto_en = 1'b1;
      for (int i = 0; i < 60 && !m_due; i++) @(negedge clk);
      c0 = cyc; req_ch = 2'b00; req = 2'b10;
      wait_sig(1, 5);
      chk("t5_req1_first", 32'(cyc - c0), 32'd1);
      req = 2'b00;
      wait_sig(3, 40);
      chk("t5_resp_id", 32'(resp_id), 32'd1);
      @(negedge clk);
      wait_sig(2, 10);
      chk("t5_auto_no_ack", 32'(n_ack - a0), 32'd1);
      chk("t5_auto_ch",     32'(conv_ch),    32'd0);
      repeat (40) @(negedge clk);
      chk("t5_latest_ch0_kept", 32'(latest_ch0), 32'h100);
      chk("t5_latest_ch1_kept", 32'(latest_ch1), 32'h3FF);
      auto_en = 1'b0;
      repeat (15) @(negedge clk);

      // reset while waiting for the engine
      r0 = n_resp; eng_delay = 0; req_ch = 2'b00; req = 2'b01;
      wait_sig(0, 10); req = 2'b00;
      wait_sig(2, 10);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      force_data = 10'h3AB; force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_no_resp",     32'(n_resp - r0), 32'd0);
      chk("t6_busy",        32'(busy),        32'd0);
      chk("t6_latest_ch0",  32'(latest_ch0),  32'd0);
      chk("t6_latest_ch1",  32'(latest_ch1),  32'd0);
      chk("t6_conv_ch",     32'(conv_ch),     32'd0);
      chk("t6_conv_start",  32'(conv_start),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_conversion_scheduler.md
Name: adc_conversion_scheduler

Overview:
Sequences the MCP3002 conversion engine: it decides when a conversion runs, on which channel, and who receives the result. Two requesters (host logic, EEPROM/I2C logger) share the engine through round-robin arbitration. A background auto-scan alternates CH0/CH1 at a fixed period and keeps the latest sample of each channel in registers. It sits between the requesters and the SPI-level ADC engine.

Parameters:
PERIOD, 1000, auto-scan interval in clk cycles (≥ 2)
TIMEOUT, 64, max cycles in WAIT for conv_done before flagging an error (≥ 2)
DW, 10, conversion data width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  2  request level per requester i; held until req_ack[i]
req_ch  in  2  requested channel for requester i (bit i: 0=CH0, 1=CH1)
req_ack  out  2  one-cycle grant pulse to requester i
auto_en  in  1  enables periodic auto-scan
conv_start  out  1  one-cycle start pulse to the ADC engine
conv_ch  out  1  channel for current conversion, stable from ISSUE to end of WAIT
conv_done  in  1  one-cycle pulse from engine, conv_data valid same cycle
conv_data  in  DW  conversion result
resp_valid  out  1  one-cycle result pulse to a requester (no backpressure)
resp_id  out  1  requester index of the result
resp_data  out  DW  result data (0 on error)
resp_err  out  1  timeout flag, qualified by resp_valid
latest_ch0  out  DW  last successful auto-scan sample, CH0
latest_ch1  out  DW  last successful auto-scan sample, CH1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; every output 0; RR pointer gives requester 0 priority; auto channel = CH0; period counter = 0; auto_due = 0. Reset mid-conversion abandons it: no resp_valid, no latest_* update, conv_start 0 from the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requesters arbitrate first. If exactly one req is high, grant it. If both are high, grant the RR-priority one, then move priority to the other.
  - Auto-scan is granted only when auto_due=1 and req=0.
  - On a grant: pulse req_ack[i] (requester grants only), latch source (REQ0/REQ1/AUTO) and channel, go to ISSUE.
  - A req dropped before ack is never granted.
- ISSUE: conv_start=1 for exactly this cycle, conv_ch driven; clear the timeout counter; go to WAIT.
- WAIT:
  - conv_done=1: capture conv_data, err=0, go to RESP.
  - Otherwise, when the timeout counter reaches TIMEOUT-1: err=1, data=0, go to RESP.
  - conv_done outside WAIT is ignored.
- RESP (1 cycle), then IDLE:
  - Requester source: resp_valid=1 with resp_id, resp_data, resp_err.
  - AUTO source: no resp_valid. On err=0, update latest_ch0 or latest_ch1. Toggle the auto channel whether or not err is set.
- Latency: req_ack in cycle n; conv_start in n+1; earliest conv_done in n+2; resp_valid in n+3. Back-to-back: the next req_ack occurs no earlier than the cycle after RESP.
- Period timer:
  - Counts 0..PERIOD-1 while auto_en=1 and sets auto_due at wrap.
  - auto_due clears when AUTO is granted. Multiple wraps while auto_due is pending collapse into one.
  - auto_en=0 holds the counter at 0 and clears auto_due. latest_* are retained.
- Width rules: counters are sized with clog2 of their parameter. The timeout counter saturates, never wraps.
- Simultaneous events: conv_done in the same cycle as the timeout threshold counts as success (err=0).

Test Plan:
- Single request: req=01, req_ch[0]=1, conv_done 3 cycles after conv_start with data 0x2A5 -> req_ack=01 once; conv_ch=1; resp_valid with id 0, data 0x2A5, err 0, exactly 5 cycles after ack.
- Contention: req=11 held continuously, engine answers in 1 cycle -> grants alternate 0,1,0,1. Each resp_id matches its grant order. No requester is granted twice in a row.
- Timeout: TIMEOUT=8, no conv_done -> resp_valid 8 cycles after WAIT entry with err=1, data=0. A later conv_done in IDLE produces no resp_valid.
- Auto-scan: PERIOD=20, auto_en=1, req=00, engine returns 0x100 then 0x3FF -> latest_ch0=0x100, latest_ch1=0x3FF. resp_valid stays 0. Starts are 20 cycles apart.
- Priority over auto: auto_due set in the same cycle req[1] rises -> requester 1 served first, auto conversion in the next IDLE. Period wraps during both conversions leave only one auto conversion pending.
- Reset mid-WAIT: assert rst for 1 cycle, then return conv_done -> all outputs 0, no resp_valid, latest_* = 0, state IDLE, busy=0.
